// File: rtl/csr_mmode_file.sv
// Machine-mode CSR file: CSRRW/RS/RC access, counters, trap/mret state, live mip and irq_take.
// Access latency 1 cycle (old value returned, write lands on the same edge); no backpressure.
module csr_mmode_file #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] MISA_VAL  = 'h40001100,
  parameter logic [XLEN-1:0] MVENDORID = '0,
  parameter logic [XLEN-1:0] MARCHID   = '0,
  parameter logic [XLEN-1:0] MIMPID    = '0,
  parameter logic [XLEN-1:0] MHARTID   = '0,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            csr_valid_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_rvalid_o,
  output logic            csr_illegal_o,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            instret_i,
  input  logic            irq_ext_i,
  input  logic            irq_tmr_i,
  input  logic            irq_sw_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_take_o
);

  localparam logic [1:0] OP_R  = 2'b00;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);

  logic            mst_mie, mst_mpie;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic            mip_meip, mip_mtip, mip_msip;
  logic            inh_cy, inh_ir;
  logic [63:0]     mcycle_q, minstret_q;

  logic [XLEN-1:0] rd_status, rd_mip, old_val, new_val;
  logic            hit, wr_try, illegal, do_wr;

  always_comb begin
    rd_status        = '0;
    rd_status[12:11] = 2'b11;
    rd_status[7]     = mst_mpie;
    rd_status[3]     = mst_mie;
    rd_mip           = '0;
    rd_mip[11]       = mip_meip;
    rd_mip[7]        = mip_mtip;
    rd_mip[3]        = mip_msip;
  end

  always_comb begin
    old_val = '0;
    hit     = 1'b1;
    case (csr_addr_i)
      12'h300: old_val = rd_status;
      12'h301: old_val = MISA_VAL;
      12'h304: old_val = mie_q;
      12'h305: old_val = mtvec_q;
      12'h340: old_val = mscratch_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      12'h344: old_val = rd_mip;
      12'h320: old_val = XLEN'({inh_ir, 1'b0, inh_cy});
      12'hB00: old_val = mcycle_q[XLEN-1:0];
      12'hB02: old_val = minstret_q[XLEN-1:0];
      12'hB80: begin old_val = XLEN'(mcycle_q[63:32]);   hit = (XLEN == 32); end
      12'hB82: begin old_val = XLEN'(minstret_q[63:32]); hit = (XLEN == 32); end
      12'hF11: old_val = MVENDORID;
      12'hF12: old_val = MARCHID;
      12'hF13: old_val = MIMPID;
      12'hF14: old_val = MHARTID;
      default: hit = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it is legal even on the read-only ID block.
  always_comb begin
    wr_try  = (csr_op_i == OP_RW) || ((csr_op_i != OP_R) && (csr_wdata_i != '0));
    illegal = !hit || (wr_try && (csr_addr_i[11:10] == 2'b11));
    do_wr   = csr_valid_i && wr_try && !illegal && !trap_i && !mret_i;
    case (csr_op_i)
      OP_RW:   new_val = csr_wdata_i;
      OP_RS:   new_val = old_val | csr_wdata_i;
      default: new_val = old_val & ~csr_wdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csr_rdata_o   <= '0;
      csr_rvalid_o  <= 1'b0;
      csr_illegal_o <= 1'b0;
      irq_take_o    <= 1'b0;
      mst_mie       <= 1'b0;
      mst_mpie      <= 1'b0;
      mie_q         <= '0;
      mtvec_q       <= MTVEC_RST;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mip_meip      <= 1'b0;
      mip_mtip      <= 1'b0;
      mip_msip      <= 1'b0;
      inh_cy        <= 1'b0;
      inh_ir        <= 1'b0;
      mcycle_q      <= '0;
      minstret_q    <= '0;
    end else begin
      csr_rvalid_o  <= csr_valid_i;
      csr_illegal_o <= csr_valid_i && illegal;
      csr_rdata_o   <= (csr_valid_i && !illegal) ? old_val : '0;
      mip_meip      <= irq_ext_i;
      mip_mtip      <= irq_tmr_i;
      mip_msip      <= irq_sw_i;
      irq_take_o    <= (|(rd_mip & mie_q)) && mst_mie;

      if (trap_i) begin
        mepc_q   <= {trap_pc_i[XLEN-1:2], 2'b00};
        mcause_q <= trap_cause_i;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (mret_i) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (do_wr) begin
        case (csr_addr_i)
          12'h300: begin mst_mie <= new_val[3]; mst_mpie <= new_val[7]; end
          12'h304: mie_q <= new_val & MIE_MASK;
          // Reserved modes 10/11 leave the mode field untouched; base always follows.
          12'h305: mtvec_q <= {new_val[XLEN-1:2], new_val[1] ? mtvec_q[1:0] : new_val[1:0]};
          12'h340: mscratch_q <= new_val;
          12'h341: mepc_q <= {new_val[XLEN-1:2], 2'b00};
          12'h342: mcause_q <= new_val;
          12'h320: begin inh_cy <= new_val[0]; inh_ir <= new_val[2]; end
          default: ;
        endcase
      end

      if (do_wr && csr_addr_i == 12'hB00)
        mcycle_q <= (XLEN == 32) ? {mcycle_q[63:32], new_val[31:0]} : 64'(new_val);
      else if (do_wr && csr_addr_i == 12'hB80)
        mcycle_q <= {new_val[31:0], mcycle_q[31:0]};
      else if (!inh_cy)
        mcycle_q <= mcycle_q + 64'd1;

      if (do_wr && csr_addr_i == 12'hB02)
        minstret_q <= (XLEN == 32) ? {minstret_q[63:32], new_val[31:0]} : 64'(new_val);
      else if (do_wr && csr_addr_i == 12'hB82)
        minstret_q <= {new_val[31:0], minstret_q[31:0]};
      else if (!inh_ir)
        minstret_q <= minstret_q + {63'd0, instret_i};
    end
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: tb/tb_csr_mmode_file.sv
// Scoreboard bench for csr_mmode_file: expected reads queued at issue, compared when rvalid fires.
module tb_csr_mmode_file;

  localparam logic [31:0] MTVEC_RST = 32'h0000_8001;
  localparam logic [31:0] MHARTID   = 32'h0000_0005;
  localparam logic [31:0] MVENDORID = 32'h0000_0ABC;
  localparam logic [31:0] MISA_VAL  = 32'h4000_1100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        csr_valid_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_rvalid_o;
  logic        csr_illegal_o;
  logic        trap_i;
  logic [31:0] trap_cause_i;
  logic [31:0] trap_pc_i;
  logic        mret_i;
  logic        instret_i;
  logic        irq_ext_i, irq_tmr_i, irq_sw_i;
  logic [31:0] mtvec_o, mepc_o;
  logic        irq_take_o;

  csr_mmode_file #(
    .XLEN(32), .MISA_VAL(MISA_VAL), .MVENDORID(MVENDORID), .MARCHID(32'h0),
    .MIMPID(32'h0), .MHARTID(MHARTID), .MTVEC_RST(MTVEC_RST)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .csr_valid_i(csr_valid_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_rvalid_o(csr_rvalid_o),
    .csr_illegal_o(csr_illegal_o), .trap_i(trap_i), .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i), .mret_i(mret_i), .instret_i(instret_i),
    .irq_ext_i(irq_ext_i), .irq_tmr_i(irq_tmr_i), .irq_sw_i(irq_sw_i),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .irq_take_o(irq_take_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rd;
    logic        chk_rd;
    logic        ill;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic chk_rd_en = 1'b1;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic access(input string tag, input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_ill);
    exp_t e;
    csr_valid_i = 1'b1;
    csr_op_i    = op;
    csr_addr_i  = addr;
    csr_wdata_i = wd;
    e.rd = exp_rd; e.chk_rd = chk_rd_en; e.ill = exp_ill; e.due = cyc + 1; e.tag = tag;
    sb.push_back(e);
    @(posedge clk_i); #1;
    csr_valid_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i) begin
      if (csr_rvalid_o) begin
        if (sb.size() == 0) begin
          check_eq("spurious_rvalid", 64'(csr_rvalid_o), 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq({e.tag, "_latency"}, 64'(cyc), 64'(e.due));
          if (e.chk_rd) check_eq({e.tag, "_rdata"}, 64'(csr_rdata_o), 64'(e.rd));
          check_eq({e.tag, "_illegal"}, 64'(csr_illegal_o), 64'(e.ill));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check_eq({e.tag, "_missing_rvalid"}, 64'(csr_rvalid_o), 64'd1);
      end
    end
  end

  initial begin
    rst_i = 1'b1; csr_valid_i = 1'b1; csr_op_i = 2'b00; csr_addr_i = 12'h300; csr_wdata_i = '0;
    trap_i = 1'b0; trap_cause_i = '0; trap_pc_i = '0; mret_i = 1'b0; instret_i = 1'b0;
    irq_ext_i = 1'b0; irq_tmr_i = 1'b0; irq_sw_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0; csr_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_discard_rvalid", 64'(csr_rvalid_o), 64'd0);
    check_eq("rst_rdata", 64'(csr_rdata_o), 64'd0);
    check_eq("rst_illegal", 64'(csr_illegal_o), 64'd0);
    check_eq("rst_irq_take", 64'(irq_take_o), 64'd0);
    check_eq("rst_mtvec_o", 64'(mtvec_o), 64'(MTVEC_RST));
    check_eq("rst_mepc_o", 64'(mepc_o), 64'd0);
    @(posedge clk_i); #1;

    access("rd_mstatus", 2'b00, 12'h300, 32'h0, 32'h0000_1800, 1'b0);
    access("rd_mtvec",   2'b00, 12'h305, 32'h0, MTVEC_RST, 1'b0);
    access("rd_mhartid", 2'b00, 12'hF14, 32'h0, MHARTID, 1'b0);

    access("scr_rw", 2'b01, 12'h340, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access("scr_rs", 2'b10, 12'h340, 32'h0000_0005, 32'hDEAD_BEEF, 1'b0);
    access("scr_rc", 2'b11, 12'h340, 32'hF000_0000, 32'hDEAD_BEEF, 1'b0);
    access("scr_rd", 2'b00, 12'h340, 32'h0, 32'h0EAD_BEEF, 1'b0);

    access("id_write",  2'b01, 12'hF11, 32'h1, 32'h0, 1'b1);
    access("unmapped",  2'b00, 12'h7C0, 32'h0, 32'h0, 1'b1);
    access("id_rs0",    2'b10, 12'hF11, 32'h0, MVENDORID, 1'b0);
    access("mtvec_rw",  2'b01, 12'h305, 32'h0000_2002, MTVEC_RST, 1'b0);
    access("mtvec_rd",  2'b00, 12'h305, 32'h0, 32'h0000_2001, 1'b0);
    access("mst_rw1",   2'b01, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0);
    access("mst_rw0",   2'b01, 12'h300, 32'h0, 32'h0000_1888, 1'b0);
    access("mie_rw1",   2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0, 1'b0);
    access("mie_rd",    2'b00, 12'h304, 32'h0, 32'h0000_0888, 1'b0);
    access("mip_wr",    2'b01, 12'h344, 32'hFFFF_FFFF, 32'h0, 1'b0);
    access("misa_wr",   2'b01, 12'h301, 32'h0, MISA_VAL, 1'b0);
    access("misa_rd",   2'b00, 12'h301, 32'h0, MISA_VAL, 1'b0);
    access("mepc_rw",   2'b01, 12'h341, 32'h0000_1237, 32'h0, 1'b0);
    access("mepc_rd",   2'b00, 12'h341, 32'h0, 32'h0000_1234, 1'b0);

    access("cych_wr", 2'b01, 12'hB80, 32'h0, 32'h0, 1'b0);
    chk_rd_en = 1'b0;
    access("cycl_wr", 2'b01, 12'hB00, 32'hFFFF_FFFF, 32'h0, 1'b0);
    chk_rd_en = 1'b1;
    access("cych_rd0", 2'b00, 12'hB80, 32'h0, 32'h0, 1'b0);
    access("cycl_wrap", 2'b00, 12'hB00, 32'h0, 32'h0, 1'b0);
    access("cych_rd1", 2'b00, 12'hB80, 32'h0, 32'h1, 1'b0);
    access("cy_set",   2'b10, 12'h320, 32'h1, 32'h0, 1'b0);
    access("cyc_frz0", 2'b00, 12'hB00, 32'h0, 32'h3, 1'b0);
    access("cyc_frz1", 2'b00, 12'hB00, 32'h0, 32'h3, 1'b0);
    access("cy_clr",   2'b11, 12'h320, 32'h1, 32'h1, 1'b0);

    access("mst_mie", 2'b01, 12'h300, 32'h0000_0008, 32'h0000_1800, 1'b0);
    access("mie_ext", 2'b01, 12'h304, 32'h0000_0800, 32'h0000_0888, 1'b0);
    irq_ext_i = 1'b1;
    @(negedge clk_i);
    check_eq("take_t0", 64'(irq_take_o), 64'd0);
    @(negedge clk_i);
    check_eq("take_t1", 64'(irq_take_o), 64'd0);
    @(negedge clk_i);
    check_eq("take_t2", 64'(irq_take_o), 64'd1);
    @(posedge clk_i); #1;
    access("mip_rd", 2'b00, 12'h344, 32'h0, 32'h0000_0800, 1'b0);
    irq_ext_i = 1'b0;

    trap_i = 1'b1; trap_cause_i = 32'h8000_000B; trap_pc_i = 32'h0000_1002;
    access("trap_wr", 2'b01, 12'h341, 32'hAAAA_0000, 32'h0000_1234, 1'b0);
    trap_i = 1'b0;
    check_eq("trap_mepc_o", 64'(mepc_o), 64'h1000);
    access("trap_mepc",   2'b00, 12'h341, 32'h0, 32'h0000_1000, 1'b0);
    access("trap_mcause", 2'b00, 12'h342, 32'h0, 32'h8000_000B, 1'b0);
    access("trap_mst",    2'b00, 12'h300, 32'h0, 32'h0000_1880, 1'b0);
    mret_i = 1'b1;
    access("mret_wr", 2'b01, 12'h340, 32'h0000_1111, 32'h0EAD_BEEF, 1'b0);
    mret_i = 1'b0;
    access("mret_scr", 2'b00, 12'h340, 32'h0, 32'h0EAD_BEEF, 1'b0);
    access("mret_mst", 2'b00, 12'h300, 32'h0, 32'h0000_1888, 1'b0);
    trap_i = 1'b1; mret_i = 1'b1; trap_cause_i = 32'h2; trap_pc_i = 32'h0000_2000;
    @(posedge clk_i); #1;
    trap_i = 1'b0; mret_i = 1'b0;
    access("both_mst", 2'b00, 12'h300, 32'h0, 32'h0000_1880, 1'b0);

    repeat (3) @(negedge clk_i);
    check_eq("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
